// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared types and helpers for the parametrised FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Read-port behaviour of the FIFO
    typedef enum logic {
        FIFO_STD  = 1'b0,   // registered read, data one cycle after pop
        FIFO_FWFT = 1'b1    // head word shown combinationally
    } fifo_mode_e;

    // Pointer width: memory index bits plus one wrap bit
    function automatic int fifo_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : fifo_mem
// Description : FIFO storage array, one synchronous write port and one
//               asynchronous read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 64,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    // Store the write word on the rising edge
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param
// Description : Single-clock FIFO with standard or first-word-fall-through
//               read, occupancy count, almost-full/empty thresholds and
//               sticky overflow/underflow flags. Extended pointers let all
//               FIFO_DEPTH entries be used.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 64,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = FIFO_DEPTH - 2,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int              c_ptr_w = fifo_ptr_width(FIFO_DEPTH);
    localparam fifo_mode_e      c_mode  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
    localparam logic [c_ptr_w-1:0] c_af = c_ptr_w'(AF_THRESH);
    localparam logic [c_ptr_w-1:0] c_ae = c_ptr_w'(AE_THRESH);

    // Elaboration-time parameter sanity
    generate
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("sync_fifo_param: FIFO_DEPTH must be a power of two >= 2");
        end
        if (ADDR_WIDTH != $clog2(FIFO_DEPTH)) begin : g_bad_addr
            $error("sync_fifo_param: ADDR_WIDTH is derived and must not be overridden");
        end
        if ((AF_THRESH < 1) || (AF_THRESH > FIFO_DEPTH)) begin : g_bad_af
            $error("sync_fifo_param: AF_THRESH out of range 1..FIFO_DEPTH");
        end
        if ((AE_THRESH < 0) || (AE_THRESH > FIFO_DEPTH - 1)) begin : g_bad_ae
            $error("sync_fifo_param: AE_THRESH out of range 0..FIFO_DEPTH-1");
        end
        if ((FWFT != 0) && (FWFT != 1)) begin : g_bad_fwft
            $error("sync_fifo_param: FWFT must be 0 or 1");
        end
    endgenerate

    logic [c_ptr_w-1:0]    w_ptr_q, w_ptr_d;
    logic [c_ptr_w-1:0]    r_ptr_q, r_ptr_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // Status decoded from current pointers only; same-cycle traffic never
    // changes what this cycle's flags say
    assign empty        = (w_ptr_q == r_ptr_q);
    assign full         = (w_ptr_q[c_ptr_w-1] != r_ptr_q[c_ptr_w-1]) &&
                          (w_ptr_q[c_ptr_w-2:0] == r_ptr_q[c_ptr_w-2:0]);
    assign count        = w_ptr_q - r_ptr_q;
    assign almost_full  = (count >= c_af);
    assign almost_empty = (count <= c_ae);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign w_wr_acc = write && !full;
    assign w_rd_acc = read  && !empty;

    // Pointer advance and sticky error accumulation
    always_comb begin
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        overflow_d  = overflow_q  | (write && full);
        underflow_d = underflow_q | (read && empty);
        if (w_wr_acc) begin
            w_ptr_d = w_ptr_q + 1'b1;
        end
        if (w_rd_acc) begin
            r_ptr_d = r_ptr_q + 1'b1;
        end
    end

    // Pointer and error-flag registers, discarded immediately on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (w_wr_acc),
        .wr_addr_i (w_ptr_q[c_ptr_w-2:0]),
        .wr_data_i (data_in),
        .rd_addr_i (r_ptr_q[c_ptr_w-2:0]),
        .rd_data_o (w_rd_data)
    );

    generate
        if (c_mode == FIFO_FWFT) begin : g_fwft
            // Head word is always on the output; read pops it
            assign data_out = w_rd_data;
            assign valid    = !empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
            logic                  valid_q, valid_d;

            // Capture the head word on an accepted read, else hold data
            always_comb begin
                data_out_d = data_out_q;
                valid_d    = 1'b0;
                if (w_rd_acc) begin
                    data_out_d = w_rd_data;
                    valid_d    = 1'b1;
                end
            end

            // Registered read-data stage
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_out_q <= '0;
                    valid_q    <= 1'b0;
                end else begin
                    data_out_q <= data_out_d;
                    valid_q    <= valid_d;
                end
            end

            assign data_out = data_out_q;
            assign valid    = valid_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_param
// Description : Directed bench for sync_fifo_param; one standard-read and one
//               FWFT instance share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          write;
    logic          read;
    logic [DW-1:0] data_in;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_valid, f_valid, s_full, f_full, s_empty, f_empty;
    logic          s_af, f_af, s_ae, f_ae, s_ovf, f_ovf, s_unf, f_unf;
    logic [AW:0]   s_count, f_count;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .DATA_WIDTH (8), .FIFO_DEPTH (8), .FWFT (0), .AF_THRESH (6), .AE_THRESH (1)
    ) u_std (
        .clk (clk), .reset (reset), .data_in (data_in), .write (write), .read (read),
        .data_out (s_dout), .valid (s_valid), .full (s_full), .empty (s_empty),
        .almost_full (s_af), .almost_empty (s_ae), .count (s_count),
        .overflow (s_ovf), .underflow (s_unf)
    );

    sync_fifo_param #(
        .DATA_WIDTH (8), .FIFO_DEPTH (8), .FWFT (1), .AF_THRESH (6), .AE_THRESH (1)
    ) u_fwft (
        .clk (clk), .reset (reset), .data_in (data_in), .write (write), .read (read),
        .data_out (f_dout), .valid (f_valid), .full (f_full), .empty (f_empty),
        .almost_full (f_af), .almost_empty (f_ae), .count (f_count),
        .overflow (f_ovf), .underflow (f_unf)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one cycle of stimulus, sample 1 time unit after the edge
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
        write   = w;
        read    = r;
        data_in = d;
        @(posedge clk);
        #1;
        write = 1'b0;
        read  = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        write   = 1'b0;
        read    = 1'b0;
        data_in = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        check_eq("rst_empty", s_empty, 1);
        check_eq("rst_ae",    s_ae,    1);
        check_eq("rst_count", s_count, 0);
        check_eq("rst_valid", s_valid, 0);
        check_eq("rst_dout",  s_dout,  0);
        check_eq("rst_full",  s_full,  0);
        check_eq("rst_af",    s_af,    0);
        check_eq("rst_fvalid", f_valid, 0);

        // Fill 8 words, thresholds tracked per step
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 8'(8'h10 + i));
            check_eq($sformatf("fill_count%0d", i), s_count, i + 1);
            check_eq($sformatf("fill_af%0d", i),    s_af,    (i + 1 >= 6) ? 1 : 0);
            check_eq($sformatf("fill_ae%0d", i),    s_ae,    (i + 1 <= 1) ? 1 : 0);
        end
        check_eq("fill_full",   s_full,  1);
        check_eq("fill_ovf0",   s_ovf,   0);
        check_eq("fill_fdout",  f_dout,  8'h10);
        check_eq("fill_fvalid", f_valid, 1);

        // Write while full
        step(1'b1, 1'b0, 8'h99);
        check_eq("ovf_set",   s_ovf,   1);
        check_eq("ovf_count", s_count, 8);
        check_eq("ovf_full",  s_full,  1);
        check_eq("ovf_unf",   s_unf,   0);

        // Drain in order
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h00);
            check_eq($sformatf("drain_dout%0d", i),  s_dout,  8'(8'h10 + i));
            check_eq($sformatf("drain_valid%0d", i), s_valid, 1);
            check_eq($sformatf("drain_count%0d", i), s_count, 7 - i);
            if (i < 7) begin
                check_eq($sformatf("drain_fdout%0d", i), f_dout, 8'(8'h11 + i));
            end
        end
        step(1'b0, 1'b0, 8'h00);
        check_eq("idle_valid",  s_valid, 0);
        check_eq("idle_hold",   s_dout,  8'h17);
        check_eq("idle_empty",  s_empty, 1);
        check_eq("idle_fvalid", f_valid, 0);

        // Fill to 5 then stream through the pointer wrap
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 8'(8'h20 + i));
        end
        check_eq("five_count", s_count, 5);
        check_eq("five_af",    s_af,    0);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b1, 8'(8'h25 + k));
            check_eq($sformatf("stream_count%0d", k), s_count, 5);
            check_eq($sformatf("stream_dout%0d", k),  s_dout,  8'(8'h20 + k));
        end
        step(1'b1, 1'b0, 8'h39);
        check_eq("six_count", s_count, 6);
        check_eq("six_af",    s_af,    1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 8'h00);
            check_eq($sformatf("tail_dout%0d", i), s_dout, 8'(8'h34 + i));
        end
        check_eq("tail_empty", s_empty, 1);

        // FWFT shows a lone word without a read
        step(1'b1, 1'b0, 8'hA5);
        check_eq("fwft_valid", f_valid, 1);
        check_eq("fwft_dout",  f_dout,  8'hA5);
        check_eq("std_novalid", s_valid, 0);
        step(1'b0, 1'b1, 8'h00);
        check_eq("fwft_pop_valid", f_valid, 0);
        check_eq("std_pop_dout",   s_dout,  8'hA5);
        check_eq("std_pop_valid",  s_valid, 1);

        // Clear sticky flags
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check_eq("clr_ovf", s_ovf, 0);
        check_eq("clr_unf", s_unf, 0);

        // Read on empty with concurrent write
        step(1'b1, 1'b1, 8'h3C);
        check_eq("unf_set",   s_unf,   1);
        check_eq("unf_count", s_count, 1);
        check_eq("unf_fdout", f_dout,  8'h3C);
        check_eq("unf_fcount", f_count, 1);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b0, 8'(8'h40 + i));
        end
        check_eq("refill_full", s_full, 1);
        check_eq("refill_ovf",  s_ovf,  0);

        // Full with write+read: pop accepted, push rejected
        step(1'b1, 1'b1, 8'h77);
        check_eq("fullrw_count", s_count, 7);
        check_eq("fullrw_ovf",   s_ovf,   1);
        check_eq("fullrw_dout",  s_dout,  8'h3C);
        check_eq("fullrw_full",  s_full,  0);

        // Asynchronous reset mid-cycle discards contents
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 8'(8'h60 + i));
        end
        check_eq("pre_arst_count", s_count, 4);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_count", s_count, 0);
        check_eq("arst_empty", s_empty, 1);
        check_eq("arst_fvalid", f_valid, 0);
        #2 reset = 1'b0;
        step(1'b1, 1'b0, 8'h55);
        check_eq("post_fdout", f_dout,  8'h55);
        check_eq("post_count", s_count, 1);
        step(1'b0, 1'b1, 8'h00);
        check_eq("post_dout",  s_dout,  8'h55);
        check_eq("post_valid", s_valid, 1);
        check_eq("post_empty", s_empty, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
